// File: rtl/riscv_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_fetch_stage_pkg
//  Purpose  : Shared constants for the instruction-fetch stage: datapath
//             width, the canonical NOP word and the default reset PC.
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_fetch_stage_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam int          INSTR_W          = 32;
  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          PC_STEP          = 4;

endpackage : riscv_fetch_stage_pkg
`default_nettype wire

// File: rtl/riscv_fetch_stage_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_fetch_stage_fetch_queue
//  Purpose  : Small synchronous FIFO of {pc, instruction} pairs between the
//             instruction-memory response port and decode.
//  Ports    : clk          - clock, rising edge
//             rst          - asynchronous active-low reset
//             i_push       - write {i_push_pc, i_push_instr}
//             i_pop        - remove head entry (ignored when empty)
//             i_flush      - discard all entries; wins over push/pop
//             o_count      - registered occupancy
//             o_head_pc    - PC of head entry
//             o_head_instr - instruction word of head entry
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_fetch_stage_fetch_queue
  import riscv_fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [XLEN-1:0]            i_push_pc,
  input  logic [INSTR_W-1:0]         i_push_instr,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [XLEN-1:0]            o_head_pc,
  output logic [INSTR_W-1:0]         o_head_instr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0]    r_pc_mem    [DEPTH];
  logic [INSTR_W-1:0] r_instr_mem [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               w_pop;

  assign w_pop = i_pop & (r_count != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]    <= '0;
        r_instr_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_pc_mem[r_wr_ptr]    <= i_push_pc;
        r_instr_mem[r_wr_ptr] <= i_push_instr;
        r_wr_ptr              <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(i_push) - CW'(w_pop);
    end
  end

  assign o_count      = r_count;
  assign o_head_pc    = r_pc_mem[r_rd_ptr];
  assign o_head_instr = r_instr_mem[r_rd_ptr];

  // The credit scheme upstream must never let a push land on a full queue.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    !(i_push && !i_flush && !w_pop && (r_count == CW'(DEPTH))));

endmodule : riscv_fetch_stage_fetch_queue
`default_nettype wire

// File: rtl/riscv_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_fetch_stage
//  Purpose  : Instruction-fetch stage. Owns the PC, issues word requests to
//             instruction memory, queues returned words with their PCs and
//             hands them to decode. A redirect flushes the queue and marks
//             every in-flight request as stale so its response is dropped.
//  Ports    : clk, rst                       - clock / async active-low reset
//             imem_req_valid/ready/addr      - fetch request channel
//             imem_rsp_valid/data            - in-order response, no stall
//             redirect_valid/pc              - restart fetch at new PC
//             if_valid/ready                 - decode handshake
//             current_pc, instruction        - presented entry
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_fetch_stage
  import riscv_fetch_stage_pkg::*;
#(
  parameter int              XLEN        = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DEFAULT_RESET_PC),
  parameter int              QUEUE_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [XLEN-1:0]    current_pc,
  output logic [INSTR_W-1:0] instruction
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic [XLEN-1:0]    r_pc;
  logic [XLEN-1:0]    r_rsp_pc;
  logic [CW-1:0]      r_outstanding;
  logic [CW-1:0]      r_drop_cnt;
  logic               r_fetch_en;
  logic [XLEN-1:0]    r_last_pc;
  logic [INSTR_W-1:0] r_last_instr;

  logic [CW-1:0]      w_q_count;
  logic [XLEN-1:0]    w_head_pc;
  logic [INSTR_W-1:0] w_head_instr;
  logic               w_credit;
  logic               w_req_valid;
  logic               w_req_fire;
  logic               w_dropping;
  logic               w_rsp_drop;
  logic               w_push;
  logic               w_if_valid;
  logic               w_pop;
  logic [CW-1:0]      w_out_next;
  logic [XLEN-1:0]    w_redirect_pc;
  logic               w_unused;

  // Credit check uses registered occupancy only: a slot freed by a pop this
  // cycle becomes available for a new request next cycle.
  assign w_credit    = ({1'b0, w_q_count} + {1'b0, r_outstanding}) < (CW+1)'(QUEUE_DEPTH);
  // r_fetch_en keeps the request low until the first edge after reset release.
  assign w_req_valid = r_fetch_en & w_credit;
  assign w_req_fire  = w_req_valid & imem_req_ready;

  assign w_dropping  = (r_drop_cnt != '0);
  assign w_rsp_drop  = imem_rsp_valid & w_dropping;
  assign w_push      = imem_rsp_valid & ~w_dropping & ~redirect_valid;
  assign w_if_valid  = (w_q_count != '0);
  assign w_pop       = w_if_valid & if_ready & ~redirect_valid;

  assign w_out_next    = r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
  assign w_redirect_pc = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused      = ^redirect_pc[1:0];

  riscv_fetch_stage_fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .XLEN  (XLEN)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_pc    (r_rsp_pc),
    .i_push_instr (imem_rsp_data),
    .i_pop        (w_pop),
    .i_flush      (redirect_valid),
    .o_count      (w_q_count),
    .o_head_pc    (w_head_pc),
    .o_head_instr (w_head_instr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_fetch_en    <= 1'b0;
      r_last_pc     <= RESET_PC;
      r_last_instr  <= NOP_INSTR;
    end else begin
      r_fetch_en    <= 1'b1;
      r_outstanding <= w_out_next;
      if (redirect_valid) begin
        // Every request still in flight after this edge (including one that
        // fires now with the old PC) belongs to the abandoned path.
        r_pc       <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
        r_drop_cnt <= w_out_next;
      end else begin
        if (w_req_fire) begin
          r_pc <= r_pc + XLEN'(PC_STEP);
        end
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + XLEN'(PC_STEP);
        end
        if (w_rsp_drop) begin
          r_drop_cnt <= r_drop_cnt - CW'(1);
        end
      end
      if (w_pop) begin
        r_last_pc    <= w_head_pc;
        r_last_instr <= w_head_instr;
      end
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign if_valid       = w_if_valid;
  // With the queue empty, decode keeps seeing the last consumed entry.
  assign current_pc     = w_if_valid ? w_head_pc    : r_last_pc;
  assign instruction    = w_if_valid ? w_head_instr : r_last_instr;

  a_rsp_expected : assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> (r_outstanding != '0));

endmodule : riscv_fetch_stage
`default_nettype wire

// File: tb/tb_riscv_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_fetch_stage
//  Purpose  : Directed self-checking bench for riscv_fetch_stage with a
//             configurable-latency instruction memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] current_pc;
  logic [31:0] instruction;

  int n_checks = 0;
  int n_errors = 0;

  int          lat  = 1;
  int          cyc  = 0;
  bit          coinc = 1'b0;
  logic [31:0] pend_addr [$];
  int          pend_due  [$];
  logic [31:0] fire_addr [$];
  logic [31:0] pop_pc    [$];
  logic [31:0] pop_ins   [$];
  int          pop_cyc   [$];

  riscv_fetch_stage u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .current_pc     (current_pc),
    .instruction    (instruction)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] get_pop_pc(input int i);
    return (i < pop_pc.size()) ? pop_pc[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] get_pop_ins(input int i);
    return (i < pop_ins.size()) ? pop_ins[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] get_fire(input int i);
    return (i < fire_addr.size()) ? fire_addr[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    fire_addr.delete();
    pop_pc.delete();
    pop_ins.delete();
    pop_cyc.delete();
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_pc    = pc;
    redirect_valid = 1'b1;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  // Memory model and monitor. Everything is decided at the falling edge so
  // the values seen are the ones the DUT samples at the next rising edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      pend_addr.delete();
      pend_due.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end else begin
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memfn(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
      if (redirect_valid && imem_req_valid && imem_req_ready && imem_rsp_valid)
        coinc = 1'b1;
      if (imem_req_valid && imem_req_ready) begin
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(cyc + lat);
        fire_addr.push_back(imem_req_addr);
      end
      if (if_valid && if_ready && !redirect_valid) begin
        pop_pc.push_back(current_pc);
        pop_ins.push_back(instruction);
        pop_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int stale;

    // ---------------- 1: reset state ----------------
    rst = 1'b0;
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    lat = 1;
    tick(10);
    check_val("rst_if_valid",  {31'b0, if_valid},       32'd0);
    check_val("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check_val("rst_req_addr",  imem_req_addr,           32'h0000_0000);
    check_val("rst_cur_pc",    current_pc,              32'h0000_0000);
    check_val("rst_instr",     instruction,             32'h0000_0013);

    // ---------------- 2: streaming ----------------
    rst = 1'b1;
    tick(1);
    check_val("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check_val("first_req_addr",  imem_req_addr,           32'h0000_0000);
    tick(12);
    check_val("stream_pc0",  get_pop_pc(0),  32'h0000_0000);
    check_val("stream_pc1",  get_pop_pc(1),  32'h0000_0004);
    check_val("stream_pc2",  get_pop_pc(2),  32'h0000_0008);
    check_val("stream_pc3",  get_pop_pc(3),  32'h0000_000C);
    check_val("stream_ins0", get_pop_ins(0), 32'h1357_9BDF);
    check_val("stream_ins3", get_pop_ins(3), 32'h1357_9BD3);
    if (pop_cyc.size() >= 4) begin
      check_val("stream_gap01", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
      check_val("stream_gap03", 32'(pop_cyc[3] - pop_cyc[0]), 32'd4);
    end else begin
      check_val("stream_pop_count", 32'(pop_cyc.size()), 32'd4);
    end

    // ---------------- 3: backpressure ----------------
    imem_req_ready = 1'b0;
    if_ready = 1'b0;
    tick(5);
    do_redirect(32'h0000_0000);
    clear_logs();
    imem_req_ready = 1'b1;
    tick(8);
    check_val("bp_fire_count", 32'(fire_addr.size()),    32'd2);
    check_val("bp_req_valid",  {31'b0, imem_req_valid},  32'd0);
    check_val("bp_if_valid",   {31'b0, if_valid},        32'd1);
    check_val("bp_head_pc",    current_pc,               32'h0000_0000);
    check_val("bp_head_ins",   instruction,              32'h1357_9BDF);
    if_ready = 1'b1;
    tick(10);
    check_val("bp_pc0", get_pop_pc(0), 32'h0000_0000);
    check_val("bp_pc1", get_pop_pc(1), 32'h0000_0004);
    check_val("bp_pc2", get_pop_pc(2), 32'h0000_0008);

    // ---------------- 4: redirect with two outstanding ----------------
    lat = 3;
    imem_req_ready = 1'b0;
    tick(6);
    do_redirect(32'h0000_0000);
    clear_logs();
    imem_req_ready = 1'b1;
    k = 0;
    while (fire_addr.size() < 2 && k < 20) begin
      tick(1);
      k++;
    end
    check_val("rd4_fires_before", 32'(fire_addr.size()), 32'd2);
    do_redirect(32'h0000_0100);
    tick(20);
    check_val("rd4_fire2", get_fire(2),    32'h0000_0100);
    check_val("rd4_pc0",   get_pop_pc(0),  32'h0000_0100);
    check_val("rd4_ins0",  get_pop_ins(0), 32'h1357_9ADF);
    check_val("rd4_pc1",   get_pop_pc(1),  32'h0000_0104);
    check_val("rd4_ins1",  get_pop_ins(1), 32'h1357_9ADB);
    stale = 0;
    foreach (pop_pc[i]) if (pop_pc[i] < 32'h100) stale++;
    check_val("rd4_stale", 32'(stale), 32'd0);

    // ---------------- 5: redirect coincident with rsp and fire ----------------
    lat = 1;
    imem_req_ready = 1'b0;
    tick(6);
    do_redirect(32'h0000_0000);
    clear_logs();
    coinc = 1'b0;
    imem_req_ready = 1'b1;
    tick(1);
    do_redirect(32'h0000_0203);
    tick(10);
    check_val("rd5_coincident", {31'b0, coinc}, 32'd1);
    check_val("rd5_fire2", get_fire(2),    32'h0000_0200);
    check_val("rd5_pc0",   get_pop_pc(0),  32'h0000_0200);
    check_val("rd5_ins0",  get_pop_ins(0), 32'h1357_99DF);
    check_val("rd5_pc1",   get_pop_pc(1),  32'h0000_0204);
    stale = 0;
    foreach (pop_pc[i]) if (pop_pc[i] < 32'h200) stale++;
    check_val("rd5_stale", 32'(stale), 32'd0);
    imem_req_ready = 1'b0;
    tick(6);
    if_ready = 1'b0;
    clear_logs();
    imem_req_ready = 1'b1;
    tick(8);
    check_val("rd5_idle_credits", 32'(fire_addr.size()), 32'd2);
    if_ready = 1'b1;
    tick(6);

    // ---------------- 6: PC wrap and mid-stream reset ----------------
    clear_logs();
    do_redirect(32'hFFFF_FFFC);
    tick(10);
    check_val("wrap_pc0",  get_pop_pc(0),  32'hFFFF_FFFC);
    check_val("wrap_pc1",  get_pop_pc(1),  32'h0000_0000);
    check_val("wrap_ins1", get_pop_ins(1), 32'h1357_9BDF);
    k = -1;
    foreach (fire_addr[i]) if (k < 0 && fire_addr[i] == 32'hFFFF_FFFC) k = i;
    check_val("wrap_fire_next", (k >= 0) ? get_fire(k + 1) : 32'hDEAD_BEEF, 32'h0000_0000);

    #1 rst = 1'b0;
    #1;
    check_val("mrst_if_valid",  {31'b0, if_valid},       32'd0);
    check_val("mrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check_val("mrst_req_addr",  imem_req_addr,           32'h0000_0000);
    check_val("mrst_cur_pc",    current_pc,              32'h0000_0000);
    check_val("mrst_instr",     instruction,             32'h0000_0013);
    tick(3);
    clear_logs();
    rst = 1'b1;
    tick(10);
    check_val("mrst_fire0", get_fire(0),    32'h0000_0000);
    check_val("mrst_pc0",   get_pop_pc(0),  32'h0000_0000);
    check_val("mrst_ins0",  get_pop_ins(0), 32'h1357_9BDF);
    check_val("mrst_pc1",   get_pop_pc(1),  32'h0000_0004);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_riscv_fetch_stage
`default_nettype wire
